// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one RAM port between an instruction fetch
// requester and a data requester.
//
// Ports:
//   CLK      - clock; all state changes on its rising edge
//   nRST     - asynchronous reset, active-high despite the name
//   iREN     - fetch request;  iaddr  fetch address
//   iload    - fetched instruction, valid only while ihit is 1
//   ihit     - fetch complete, one-cycle pulse
//   dREN     - data read request; dWEN data write request
//   daddr    - data address;   dstore write data
//   dload    - read data, valid only while dhit is 1
//   dhit     - data access complete, one-cycle pulse
//   ramREN   - RAM read strobe;  ramWEN RAM write strobe
//   ramaddr  - RAM address;      ramstore RAM write data
//   ramload  - RAM read data
//   ramstate - RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
//   err      - sticky error flag, cleared only by reset
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        ihit,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dhit,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, DACC, IACC, ERR} state_t;
   typedef enum logic {GNT_I, GNT_D} grant_t;

   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;
   localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

   state_t     state, next_state;
   grant_t     last_grant;
   logic [7:0] wait_cnt;
   logic       d_req;
   logic       timed_out;

   assign d_req = dREN | dWEN;
   // This busy cycle is the TIMEOUT-th one spent waiting in the access.
   assign timed_out = ({1'b0, wait_cnt} + 9'd1) >= TIMEOUT_LIM;

   always_ff @(posedge CLK or posedge nRST) begin
      if (nRST) begin
         state      <= IDLE;
         last_grant <= GNT_I;
         wait_cnt   <= '0;
      end else begin
         state <= next_state;
         if (dhit)
            last_grant <= GNT_D;
         else if (ihit)
            last_grant <= GNT_I;
         // Held at zero outside the access states, so entry starts from 0.
         if (state == DACC || state == IACC)
            wait_cnt <= wait_cnt + 8'd1;
         else
            wait_cnt <= '0;
      end
   end

   always_comb begin
      next_state = state;
      iload      = '0;
      ihit       = 1'b0;
      dload      = '0;
      dhit       = 1'b0;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      err        = 1'b0;
      unique case (state)
         IDLE: begin
            if (d_req && iREN)
               next_state = (last_grant == GNT_I) ? DACC : IACC;
            else if (d_req)
               next_state = DACC;
            else if (iREN)
               next_state = IACC;
         end
         DACC: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            if (ramstate == RS_ACCESS) begin
               dhit       = 1'b1;
               dload      = ramload;
               next_state = IDLE;
            end else if (ramstate == RS_ERROR) begin
               next_state = ERR;
            end else if (!d_req) begin
               next_state = IDLE;
            end else if (timed_out) begin
               next_state = ERR;
            end
         end
         IACC: begin
            ramaddr = iaddr;
            ramREN  = 1'b1;
            if (ramstate == RS_ACCESS) begin
               ihit       = 1'b1;
               iload      = ramload;
               next_state = IDLE;
            end else if (ramstate == RS_ERROR) begin
               next_state = ERR;
            end else if (!iREN) begin
               next_state = IDLE;
            end else if (timed_out) begin
               next_state = ERR;
            end
         end
         ERR: begin
            err = 1'b1;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by randomized traffic, all
// checked against a transaction-level reference model of the arbiter.
module tb_mem_arbiter;

   localparam int unsigned TO = 4;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        ihit;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic [31:0] dload;
   logic        dhit;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
   logic        err;

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dhit(dhit),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
      .err(err)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: who owns the RAM (0 nobody, 1 data, 2 fetch,
   // 3 faulted), how long the owner has waited, and who wins a tie next.
   int m_owner;
   int m_waited;
   bit m_prefer_i;

   function automatic logic [132:0] dut_vec();
      return {iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err};
   endfunction

   function automatic logic [132:0] model_out();
      logic [31:0] il, dl, ra, rs;
      logic        ih, dh, rr, rw, e;
      il = '0; dl = '0; ra = '0; rs = '0;
      ih = 1'b0; dh = 1'b0; rr = 1'b0; rw = 1'b0; e = 1'b0;
      if (m_owner == 1) begin
         ra = daddr;
         rs = dstore;
         rw = dWEN;
         rr = dREN && !dWEN;
         if (ramstate == 2'd2) begin
            dh = 1'b1;
            dl = ramload;
         end
      end else if (m_owner == 2) begin
         ra = iaddr;
         rr = 1'b1;
         if (ramstate == 2'd2) begin
            ih = 1'b1;
            il = ramload;
         end
      end else if (m_owner == 3) begin
         e = 1'b1;
      end
      return {il, ih, dl, dh, rr, rw, ra, rs, e};
   endfunction

   task automatic model_reset();
      m_owner    = 0;
      m_waited   = 0;
      m_prefer_i = 1'b0;
   endtask

   task automatic model_tick();
      bit want_d, want_i, still;
      want_d = dREN || dWEN;
      want_i = iREN;
      if (m_owner == 0) begin
         m_waited = 0;
         if (want_d && want_i) m_owner = m_prefer_i ? 2 : 1;
         else if (want_d)      m_owner = 1;
         else if (want_i)      m_owner = 2;
      end else if (m_owner == 1 || m_owner == 2) begin
         still = (m_owner == 1) ? want_d : want_i;
         if (ramstate == 2'd2) begin
            m_prefer_i = (m_owner == 1);
            m_owner    = 0;
         end else if (ramstate == 2'd3) begin
            m_owner = 3;
         end else if (!still) begin
            m_owner = 0;
         end else begin
            m_waited = m_waited + 1;
            if (m_waited >= int'(TO)) m_owner = 3;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [132:0] obs, input logic [132:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic half(input string tag);
      @(negedge CLK);
      chk(tag, dut_vec(), model_out());
   endtask

   task automatic tick();
      @(posedge CLK);
      model_tick();
      #1;
   endtask

   task automatic apply_reset();
      nRST = 1'b1;
      #1;
      model_reset();
      chk("reset_all_zero", dut_vec(), 133'd0);
      @(posedge CLK);
      #1;
      nRST = 1'b0;
   endtask

   initial begin
      int r;
      nRST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
      model_reset();
      apply_reset();

      // Data read: two BUSY cycles then ACCESS.
      dREN = 1'b1; daddr = 32'h100; ramstate = 2'd1; ramload = 32'hDEADBEEF;
      half("rd_idle");
      chk("rd_idle_ren", ramREN, 1'b0);
      tick();
      half("rd_busy1");
      chk("rd_busy1_ren", ramREN, 1'b1);
      chk("rd_busy1_dhit", dhit, 1'b0);
      chk("rd_busy1_dload", dload, 32'h0);
      tick();
      half("rd_busy2");
      chk("rd_busy2_ren", ramREN, 1'b1);
      tick();
      ramstate = 2'd2;
      half("rd_access");
      chk("rd_acc_ren", ramREN, 1'b1);
      chk("rd_acc_dhit", dhit, 1'b1);
      chk("rd_acc_dload", dload, 32'hDEADBEEF);
      chk("rd_acc_addr", ramaddr, 32'h100);
      tick();
      dREN = 1'b0;
      half("rd_after");
      chk("rd_after_ren", ramREN, 1'b0);
      chk("rd_after_dhit", dhit, 1'b0);
      tick();

      // Fetch aborted after one BUSY cycle; tie-break preference must survive.
      iREN = 1'b1; iaddr = 32'h0000_0500; ramstate = 2'd1;
      half("ab_idle");
      tick();
      half("ab_busy");
      chk("ab_busy_ihit", ihit, 1'b0);
      tick();
      iREN = 1'b0;
      half("ab_drop");
      chk("ab_drop_ihit", ihit, 1'b0);
      tick();
      half("ab_idle2");
      chk("ab_idle2_ren", ramREN, 1'b0);
      iREN = 1'b1; dREN = 1'b1; ramstate = 2'd2; ramload = 32'h1111_2222;
      tick();
      half("ab_tie");
      chk("ab_tie_ihit", ihit, 1'b1);
      chk("ab_tie_dhit", dhit, 1'b0);
      chk("ab_tie_iload", iload, 32'h1111_2222);
      iREN = 1'b0; dREN = 1'b0;
      tick();

      // Alternating grants with both requesters held and RAM always ready.
      apply_reset();
      iREN = 1'b1; dWEN = 1'b1; dstore = 32'h1234_5678;
      daddr = 32'h200; iaddr = 32'h300; ramstate = 2'd2; ramload = 32'hCAFE_F00D;
      for (int k = 0; k < 8; k++) begin
         half("alt");
         chk("alt_dhit", dhit, ((k % 4) == 1) ? 1'b1 : 1'b0);
         chk("alt_ihit", ihit, ((k % 4) == 3) ? 1'b1 : 1'b0);
         if (k == 1) begin
            chk("alt_first_wen", ramWEN, 1'b1);
            chk("alt_first_store", ramstore, 32'h1234_5678);
         end
         tick();
      end
      iREN = 1'b0; dWEN = 1'b0;

      // Read and write together: write wins.
      dREN = 1'b1; dWEN = 1'b1; daddr = 32'h40; ramstate = 2'd1;
      half("rw_idle");
      tick();
      half("rw_dacc");
      chk("rw_wen", ramWEN, 1'b1);
      chk("rw_ren", ramREN, 1'b0);
      chk("rw_addr", ramaddr, 32'h40);
      tick();
      dREN = 1'b0; dWEN = 1'b0;
      half("rw_drop");
      tick();

      // Timeout: fetch stuck on BUSY.
      apply_reset();
      iREN = 1'b1; ramstate = 2'd1;
      half("to_idle");
      tick();
      for (int k = 0; k < 4; k++) begin
         half("to_wait");
         chk("to_wait_err", err, 1'b0);
         chk("to_wait_ren", ramREN, 1'b1);
         tick();
      end
      half("to_err");
      chk("to_err_flag", err, 1'b1);
      chk("to_err_ren", ramREN, 1'b0);
      iREN = 1'b0; dREN = 1'b1; ramstate = 2'd2;
      for (int k = 0; k < 3; k++) begin
         tick();
         half("to_hold");
         chk("to_hold_err", err, 1'b1);
         chk("to_hold_dhit", dhit, 1'b0);
      end
      dREN = 1'b0;
      tick();
      apply_reset();
      half("to_cleared");
      chk("to_cleared_err", err, 1'b0);
      tick();

      // Reset asserted between edges in the middle of a data access.
      dREN = 1'b1; daddr = 32'h80; ramstate = 2'd1;
      half("mr_idle");
      tick();
      ramstate = 2'd2;
      half("mr_dacc");
      chk("mr_pre_ren", ramREN, 1'b1);
      chk("mr_pre_dhit", dhit, 1'b1);
      #1;
      nRST = 1'b1;
      #1;
      chk("mr_ren", ramREN, 1'b0);
      chk("mr_dhit", dhit, 1'b0);
      chk("mr_dload", dload, 32'h0);
      model_reset();
      @(posedge CLK);
      #1;
      nRST = 1'b0;
      dREN = 1'b0;

      // Randomized traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 3) == 0) iREN = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) dREN = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 5) == 0) dWEN = ($urandom_range(0, 2) == 0);
         iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
         r = int'($urandom_range(0, 59));
         ramstate = (r == 0) ? 2'd3 : (r < 22) ? 2'd2 : (r < 26) ? 2'd0 : 2'd1;
         half("rand");
         if ((m_owner == 3 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
            apply_reset();
         else
            tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL be the maximum cycles one RAM access may remain unfinished before error.
REQ-002 Port list (name, direction, width, meaning) SHALL be:
- CLK  in  1  single clock; all state changes on its rising edge.
- nRST  in  1  asynchronous reset, active-high (asserted when 1).
- iREN  in  1  instruction fetch request.
- iaddr  in  32  fetch address.
- iload  out  32  fetched instruction.
- ihit  out  1  fetch complete, one-cycle pulse.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dload  out  32  read data.
- dhit  out  1  data access complete, one-cycle pulse.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- err  out  1  sticky error flag.

Function
REQ-003 States SHALL be IDLE, DACC, IACC and ERR, encoded in one registered state variable.
REQ-004 In IDLE, all RAM strobes SHALL be 0; with no request pending, state SHALL stay IDLE.
REQ-005 In IDLE, if only a data request (dREN|dWEN) is pending, next state SHALL be DACC; if only iREN is pending, next state SHALL be IACC.
REQ-006 If both data and iREN are pending in IDLE, the grant SHALL go opposite to register last_grant; last_grant SHALL reset to I, so data is granted first after reset.
REQ-007 last_grant SHALL update to D or I on every completed access (hit), not on an abort.
REQ-008 In DACC, ramaddr SHALL be daddr and ramstore SHALL be dstore.
REQ-009 In DACC, ramWEN SHALL equal dWEN and ramREN SHALL equal dREN & ~dWEN; write wins when both are high.
REQ-010 In IACC, ramaddr SHALL be iaddr, ramREN SHALL be 1, and ramWEN SHALL be 0.
REQ-011 In DACC, when ramstate==ACCESS, dhit SHALL be 1 combinationally in that cycle and dload SHALL equal ramload (on reads); next state SHALL be IDLE.
REQ-012 In IACC, when ramstate==ACCESS, ihit SHALL be 1 and iload SHALL equal ramload; next state SHALL be IDLE.
REQ-013 dload and iload SHALL be 0 whenever their hit is 0; at most one of ihit and dhit SHALL be 1 in any cycle.
REQ-014 Minimum latency from request in IDLE to hit SHALL be 1 cycle: grant edge, then hit in the first cycle ramstate==ACCESS.
REQ-015 If the owning request deasserts while in DACC or IACC (no ACCESS that cycle), the access SHALL abort to IDLE with no hit and no last_grant change.
REQ-016 An 8-bit wait counter SHALL clear on entry to DACC or IACC and increment each cycle in those states without ACCESS.
REQ-017 When the wait counter reaches TIMEOUT, or ramstate==ERROR in DACC or IACC, next state SHALL be ERR.
REQ-018 In ERR, err SHALL be 1, strobes and hits SHALL be 0, and the state SHALL hold until reset.
REQ-019 Request inputs SHALL be sampled only in IDLE; changes to the address or data of a granted request take effect combinationally on the RAM outputs.

Reset
REQ-020 nRST=1 SHALL immediately, without waiting for a clock edge, force: state IDLE, last_grant I, wait counter 0, err 0, all strobes, hits, loads and RAM outputs 0.
REQ-021 Reset asserted mid-access SHALL drop ramREN/ramWEN in the same cycle, with no hit generated.
REQ-022 After nRST deasserts, the first grant SHALL occur at the next rising CLK edge if a request is present.

Verification
REQ-023 The bench SHALL cover: dREN=1, daddr=0x100, ramstate BUSY 2 cycles then ACCESS with ramload=0xDEADBEEF -> ramREN=1 for 3 cycles, dhit pulses once with dload=0xDEADBEEF, state IDLE next.
REQ-024 The bench SHALL cover: iREN=1 and dWEN=1 held, RAM always ACCESS -> grants alternate D,I,D,I; first dhit with ramWEN=1, ramstore=dstore.
REQ-025 The bench SHALL cover: dREN=dWEN=1, daddr=0x40 -> ramWEN=1, ramREN=0, ramaddr=0x40.
REQ-026 The bench SHALL cover: TIMEOUT=4, iREN=1, ramstate stuck BUSY -> err=1 after 4 waiting cycles, remaining 1 until nRST pulse, then 0.
REQ-027 The bench SHALL cover: iREN drop after 1 BUSY cycle -> no ihit, IDLE next, last_grant unchanged.
REQ-028 The bench SHALL cover: nRST=1 mid-DACC between clock edges -> ramREN=0 and dhit=0 before the next edge.
